// File: rtl/wb_pkg.sv
// Shared Wishbone B3 burst encodings and the burst initiator's FSM state type.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StBus,
        StBackoff,
        StDone
    } wb_state_e;

    // Cycle type for the beat about to be presented on the bus.
    function automatic logic [2:0] cti_for(input logic single, input logic last);
        if (single) begin
            return CTI_CLASSIC;
        end
        return last ? CTI_EOB : CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_burst_fifo.sv
// Synchronous first-word fall-through FIFO holding one burst of write data.
module wb_burst_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_burst_mst.sv
// Wishbone B3 linear incrementing burst initiator with buffered writes and streamed reads.
// Define WB_BURST_MST_RTY_EN to enable retry/backoff; otherwise rty is treated as err.
module wb_burst_mst
    import wb_pkg::*;
#(
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned RTY_MAX   = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [31:0]                  cmd_adr,
    input  logic [$clog2(BURST_MAX)-1:0] cmd_len,
    input  logic                         cmd_we,
    input  logic [3:0]                   cmd_sel,
    input  logic                         wdat_valid,
    output logic                         wdat_ready,
    input  logic [31:0]                  wdat,
    output logic                         rdat_valid,
    output logic [31:0]                  rdat,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  wbm_adr_o,
    output logic [31:0]                  wbm_dat_o,
    output logic [3:0]                   wbm_sel_o,
    output logic                         wbm_we_o,
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic [2:0]                   wbm_cti_o,
    output logic [1:0]                   wbm_bte_o,
    input  logic [31:0]                  wbm_dat_i,
    input  logic                         wbm_ack_i,
    input  logic                         wbm_err_i,
    input  logic                         wbm_rty_i
);

    localparam int unsigned LW = $clog2(BURST_MAX);
    localparam int unsigned CW = LW + 1;

    wb_state_e     state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [LW-1:0] len_q, len_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic          cyc_q, cyc_d;
    logic [2:0]    cti_q, cti_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          rdat_valid_q, rdat_valid_d;
    logic          err_q, err_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [31:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          bus_err;
    logic          bus_rty;

`ifdef WB_BURST_MST_RTY_EN
    localparam int unsigned RW = $clog2(RTY_MAX + 2);

    logic [RW-1:0] rty_cnt_q, rty_cnt_d;
    logic          rty_exhausted;

    assign bus_err       = wbm_err_i;
    assign bus_rty       = wbm_rty_i && !wbm_err_i;
    assign rty_exhausted = (32'(rty_cnt_q) + 32'd1) > RTY_MAX;

    always_comb begin
        rty_cnt_d = rty_cnt_q;
        if (state_q == StIdle) begin
            rty_cnt_d = '0;
        end else if (state_q == StBus) begin
            if (bus_rty) begin
                rty_cnt_d = rty_cnt_q + RW'(1);
            end else if (wbm_ack_i && !bus_err) begin
                rty_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rty_cnt_q <= '0;
        end else begin
            rty_cnt_q <= rty_cnt_d;
        end
    end
`else
    assign bus_err = wbm_err_i || wbm_rty_i;
    assign bus_rty = 1'b0;
`endif

    wb_burst_fifo #(
        .DEPTH (BURST_MAX),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (wdat),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign cmd_ready  = (state_q == StIdle) && !rst;
    assign wdat_ready = (state_q == StLoad) && (fifo_count <= CW'(len_q));
    assign fifo_push  = wdat_valid && wdat_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = cmd_we ? StLoad : StBus;
                end
            end
            StLoad: begin
                if (fifo_push && (fifo_count == CW'(len_q))) begin
                    state_d = StBus;
                end
            end
            StBus: begin
                if (bus_err) begin
                    state_d = StDone;
                end
`ifdef WB_BURST_MST_RTY_EN
                else if (bus_rty) begin
                    state_d = rty_exhausted ? StDone : StBackoff;
                end
`endif
                else if (wbm_ack_i && (rem_q == '0)) begin
                    state_d = StDone;
                end
            end
`ifdef WB_BURST_MST_RTY_EN
            StBackoff: state_d = StBus;
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus-facing values are computed from the next state so they register with it.
    always_comb begin
        adr_d        = adr_q;
        rem_d        = rem_q;
        len_d        = len_q;
        we_d         = we_q;
        sel_d        = sel_q;
        err_d        = err_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    adr_d = cmd_adr & 32'hFFFF_FFFC;
                    rem_d = cmd_len;
                    len_d = cmd_len;
                    we_d  = cmd_we;
                    sel_d = cmd_sel;
                    err_d = 1'b0;
                end
            end
            StBus: begin
                if (bus_err) begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                end
`ifdef WB_BURST_MST_RTY_EN
                else if (bus_rty) begin
                    if (rty_exhausted) begin
                        err_d      = 1'b1;
                        fifo_flush = 1'b1;
                    end
                end
`endif
                else if (wbm_ack_i) begin
                    adr_d        = adr_q + 32'd4;
                    fifo_pop     = we_q;
                    rdat_valid_d = !we_q;
                    if (!we_q) begin
                        rdat_d = wbm_dat_i;
                    end
                    if (rem_q != '0) begin
                        rem_d = rem_q - LW'(1);
                    end
                end
            end
            default: ;
        endcase
        cyc_d = (state_d == StBus);
        cti_d = cyc_d ? cti_for(len_d == '0, rem_d == '0) : CTI_CLASSIC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q        <= '0;
            rem_q        <= '0;
            len_q        <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            cyc_q        <= 1'b0;
            cti_q        <= CTI_CLASSIC;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            adr_q        <= adr_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            cyc_q        <= cyc_d;
            cti_q        <= cti_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            err_q        <= err_d;
        end
    end

    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = (cyc_q && we_q) ? fifo_rdata : '0;
    assign wbm_sel_o  = sel_q;
    assign wbm_we_o   = we_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_cti_o  = cti_q;
    assign wbm_bte_o  = BTE_LINEAR;
    assign rdat       = rdat_q;
    assign rdat_valid = rdat_valid_q;
    assign done       = (state_q == StDone);
    assign err        = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_wb_burst_mst.sv
// Directed bench for wb_burst_mst: reads, writes, err, retry, and mid-burst reset.
module tb_wb_burst_mst;

    localparam int ModeAck    = 0;
    localparam int ModeErr    = 1;
    localparam int ModeRty1   = 2;
    localparam int ModeRtyAll = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [2:0]  cmd_len;
    logic [3:0]  cmd_sel;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat;
    logic        rdat_valid, done, err;
    logic [31:0] rdat;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] wbuf [8];
    logic [31:0] b_adr [16];
    logic [2:0]  b_cti [16];
    logic [31:0] b_dat [16];
    logic [3:0]  b_sel [16];
    logic        b_we  [16];
    logic [31:0] rd_log [16];
    logic [2:0]  exp_cti [4];
    int nb, nrd, ndone, done_cyc, attempts, gaps, stb_bad, ncyc, fifo_at_done, rst_fifo;
    int mode, mode_beat, rst_beat;
    logic done_err, done_cyc_o, after_ready, rst_cyc_after;

    wb_burst_mst #(
        .BURST_MAX (8),
        .RTY_MAX   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .cmd_we     (cmd_we),
        .cmd_sel    (cmd_sel),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .rdat_valid (rdat_valid),
        .rdat       (rdat),
        .done       (done),
        .err        (err),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_cti_o  (wbm_cti_o),
        .wbm_bte_o  (wbm_bte_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .wbm_rty_i  (wbm_rty_i)
    );

    always #5 clk = ~clk;

    // Slave read data is a fixed function of the address.
    assign wbm_dat_i = {16'hA5A5, wbm_adr_o[15:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one command at a negedge and play the slave until done or the cycle budget runs out.
    task automatic run_cmd(input logic [31:0] a, input logic [2:0] l, input logic w,
                           input logic [3:0] s, input int budget);
        int   idx, bus_n, to;
        logic pushed, prev_cyc, rst_pend;
        nb = 0; nrd = 0; ndone = 0; done_cyc = 0; attempts = 0; gaps = 0; stb_bad = 0;
        done_err = 1'b0; done_cyc_o = 1'b0; fifo_at_done = -1; rst_fifo = -1;
        rst_cyc_after = 1'b1; idx = 0; bus_n = 0; pushed = 1'b0; prev_cyc = 1'b0;
        rst_pend = 1'b0;
        cmd_adr = a; cmd_len = l; cmd_we = w; cmd_sel = s; cmd_valid = 1'b1;
        to = 0;
        while (!cmd_ready && to < 20) begin
            @(negedge clk);
            to++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        wdat = wbuf[0];
        wdat_valid = w;
        ncyc = 1;
        while (ndone == 0 && ncyc < budget) begin
            @(negedge clk);
            ncyc++;
            cmd_valid = 1'b0;
            if (rst_pend) begin
                rst = 1'b0;
                rst_pend = 1'b0;
                rst_cyc_after = wbm_cyc_o;
                rst_fifo = int'(dut.fifo_count);
            end
            if (pushed) begin
                idx++;
                wdat = wbuf[idx % 8];
                if (idx == int'(l) + 1) wdat_valid = 1'b0;
            end
            pushed = wdat_valid && wdat_ready;
            if (wbm_stb_o !== wbm_cyc_o) stb_bad++;
            if (wbm_cyc_o && !prev_cyc) attempts++;
            if (attempts > 0 && !wbm_cyc_o && !done) gaps++;
            if (rdat_valid && nrd < 16) begin
                rd_log[nrd] = rdat;
                nrd++;
            end
            if (done) begin
                ndone++;
                done_cyc = ncyc;
                done_err = err;
                done_cyc_o = wbm_cyc_o;
                fifo_at_done = int'(dut.fifo_count);
            end
            prev_cyc = wbm_cyc_o;
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
            if (wbm_cyc_o) begin
                if (rst_beat == bus_n) begin
                    rst = 1'b1;
                    rst_pend = 1'b1;
                end else begin
                    case (mode)
                        ModeErr:    if (bus_n == mode_beat) wbm_err_i = 1'b1; else wbm_ack_i = 1'b1;
                        ModeRty1:   if (bus_n == mode_beat) wbm_rty_i = 1'b1; else wbm_ack_i = 1'b1;
                        ModeRtyAll: wbm_rty_i = 1'b1;
                        default:    wbm_ack_i = 1'b1;
                    endcase
                end
                if (wbm_ack_i && nb < 16) begin
                    b_adr[nb] = wbm_adr_o; b_cti[nb] = wbm_cti_o; b_dat[nb] = wbm_dat_o;
                    b_sel[nb] = wbm_sel_o; b_we[nb] = wbm_we_o;
                    nb++;
                end
                bus_n++;
            end
        end
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        @(negedge clk);
        after_ready = cmd_ready;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_we = 1'b0; cmd_sel = '0;
        wdat_valid = 1'b0; wdat = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
        mode = ModeAck; mode_beat = 0; rst_beat = -1;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel_we", {27'd0, wbm_sel_o, wbm_we_o}, 32'd0);
        chk("rst_cti_bte", {27'd0, wbm_cti_o, wbm_bte_o}, 32'd0);
        chk("rst_status", {28'd0, cmd_ready, wdat_ready, done, err}, 32'd0);
        chk("rst_rdat", {31'd0, rdat_valid} | rdat, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(cmd_ready), 32'd1);

        // 4-beat read, ack held high.
        exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111};
        run_cmd(32'h4000_0010, 3'd3, 1'b0, 4'hF, 40);
        chk("rd4_done", 32'(ndone), 32'd1);
        chk("rd4_done_cyc", 32'(done_cyc), 32'd6);
        chk("rd4_err", 32'(done_err), 32'd0);
        chk("rd4_beats", 32'(nb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rd4_adr", b_adr[i], 32'h4000_0010 + 32'(4 * i));
            chk("rd4_cti", 32'(b_cti[i]), 32'(exp_cti[i]));
        end
        chk("rd4_nrd", 32'(nrd), 32'd4);
        chk("rd4_rdat0", rd_log[0], 32'hA5A5_0010);
        chk("rd4_rdat3", rd_log[3], 32'hA5A5_001C);
        chk("rd4_stb", 32'(stb_bad), 32'd0);
        chk("rd4_bte", 32'(wbm_bte_o), 32'd0);
        chk("rd4_ready_after", 32'(after_ready), 32'd1);

        // Single-beat write with an unaligned address.
        wbuf[0] = 32'hDEAD_BEEF;
        run_cmd(32'h0000_0022, 3'd0, 1'b1, 4'b0011, 40);
        chk("wr1_done", 32'(ndone), 32'd1);
        chk("wr1_done_cyc", 32'(done_cyc), 32'd4);
        chk("wr1_err", 32'(done_err), 32'd0);
        chk("wr1_beats", 32'(nb), 32'd1);
        chk("wr1_adr", b_adr[0], 32'h0000_0020);
        chk("wr1_cti", 32'(b_cti[0]), 32'd0);
        chk("wr1_we", 32'(b_we[0]), 32'd1);
        chk("wr1_sel", 32'(b_sel[0]), 32'h3);
        chk("wr1_dat", b_dat[0], 32'hDEAD_BEEF);
        chk("wr1_nrd", 32'(nrd), 32'd0);

        // 4-beat write, err on beat 2.
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
        wbuf[2] = 32'h3333_3333; wbuf[3] = 32'h4444_4444;
        mode = ModeErr; mode_beat = 2;
        run_cmd(32'h0000_1000, 3'd3, 1'b1, 4'hF, 40);
        chk("wrerr_done", 32'(ndone), 32'd1);
        chk("wrerr_done_cyc", 32'(done_cyc), 32'd9);
        chk("wrerr_err", 32'(done_err), 32'd1);
        chk("wrerr_beats", 32'(nb), 32'd2);
        chk("wrerr_adr1", b_adr[1], 32'h0000_1004);
        chk("wrerr_dat1", b_dat[1], 32'h2222_2222);
        chk("wrerr_cyc_drop", 32'(done_cyc_o), 32'd0);
        chk("wrerr_fifo", 32'(fifo_at_done), 32'd0);
        chk("wrerr_ready_after", 32'(after_ready), 32'd1);

        // 4-beat read, rty on beat 1 then acks.
        mode = ModeRty1; mode_beat = 1;
        run_cmd(32'h0000_0100, 3'd3, 1'b0, 4'hF, 40);
        chk("rty1_done", 32'(ndone), 32'd1);
`ifdef WB_BURST_MST_RTY_EN
        chk("rty1_err", 32'(done_err), 32'd0);
        chk("rty1_done_cyc", 32'(done_cyc), 32'd8);
        chk("rty1_gaps", 32'(gaps), 32'd1);
        chk("rty1_attempts", 32'(attempts), 32'd2);
        chk("rty1_beats", 32'(nb), 32'd4);
        chk("rty1_resume_adr", b_adr[1], 32'h0000_0104);
        chk("rty1_resume_cti", 32'(b_cti[1]), 32'h2);
        chk("rty1_nrd", 32'(nrd), 32'd4);
        chk("rty1_rdat1", rd_log[1], 32'hA5A5_0104);
`else
        chk("rty1_err", 32'(done_err), 32'd1);
        chk("rty1_done_cyc", 32'(done_cyc), 32'd4);
        chk("rty1_attempts", 32'(attempts), 32'd1);
        chk("rty1_nrd", 32'(nrd), 32'd1);
`endif

        // rty held permanently, RTY_MAX = 2.
        mode = ModeRtyAll;
        run_cmd(32'h0000_0300, 3'd1, 1'b0, 4'hF, 40);
        chk("rtyall_done", 32'(ndone), 32'd1);
        chk("rtyall_err", 32'(done_err), 32'd1);
        chk("rtyall_beats", 32'(nb), 32'd0);
`ifdef WB_BURST_MST_RTY_EN
        chk("rtyall_attempts", 32'(attempts), 32'd3);
        chk("rtyall_done_cyc", 32'(done_cyc), 32'd7);
`else
        chk("rtyall_attempts", 32'(attempts), 32'd1);
        chk("rtyall_done_cyc", 32'(done_cyc), 32'd3);
`endif

        // Reset during beat 2 of an 8-beat write, then a normal read.
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
        mode = ModeAck; rst_beat = 2;
        run_cmd(32'h0000_2000, 3'd7, 1'b1, 4'hF, 24);
        chk("rstmid_done", 32'(ndone), 32'd0);
        chk("rstmid_beats", 32'(nb), 32'd2);
        chk("rstmid_cyc", 32'(rst_cyc_after), 32'd0);
        chk("rstmid_fifo", 32'(rst_fifo), 32'd0);
        chk("rstmid_ready", 32'(after_ready), 32'd1);
        rst_beat = -1;
        run_cmd(32'h0000_0200, 3'd1, 1'b0, 4'hF, 40);
        chk("post_done", 32'(ndone), 32'd1);
        chk("post_err", 32'(done_err), 32'd0);
        chk("post_done_cyc", 32'(done_cyc), 32'd4);
        chk("post_nrd", 32'(nrd), 32'd2);
        chk("post_rdat1", rd_log[1], 32'hA5A5_0204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_mst.md
# wb_burst_mst

Wishbone B3 burst initiator: the master-side counterpart to the memory controller's Wishbone slave port. It accepts a simple command (address, beat count, direction, byte lanes) and issues one linear incrementing burst with CTI/BTE signalling. Write data is buffered in full before the bus is requested, and read data is streamed out beat by beat. It sits between an internal engine (DMA, cache refill) and the main Wishbone slave port of the memory controller.

## Interface
- BURST_MAX, 8: maximum beats per command; power of two, 2..16.
- RTY_MAX, 15: maximum consecutive retries before the command fails.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_adr  in  32  start byte address; bits [1:0] ignored and driven 0.
- cmd_len  in  log2(BURST_MAX)  beats minus one.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  4  byte lanes, applied to every beat.
- wdat_valid / wdat_ready  in / out  1  write-data handshake.
- wdat  in  32  write data word.
- rdat_valid  out  1  read beat strobe; no backpressure.
- rdat  out  32  read beat data.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = command failed.
- wbm_adr_o  out  32;  wbm_dat_o  out  32;  wbm_sel_o  out  4;  wbm_we_o  out  1.
- wbm_cyc_o, wbm_stb_o  out  1.
- wbm_cti_o  out  3;  wbm_bte_o  out  2 (always 2'b00, linear).
- wbm_dat_i  in  32;  wbm_ack_i, wbm_err_i, wbm_rty_i  in  1.

## Operation
- FSM states: IDLE, LOAD, BUS, BACKOFF, DONE.
- IDLE
  - cmd_ready=1.
  - On accept, latch address (aligned), beat count, we and sel.
  - Go to LOAD for writes, BUS for reads.
- LOAD
  - wdat_ready=1 while the FIFO holds fewer than cmd_len+1 words; one word is pushed per handshake.
  - Go to BUS on the cycle after the last word is pushed.
- BUS
  - cyc=stb=1.
  - CTI encoding:
    - Single-beat command: CTI 000.
    - Multi-beat command: CTI 010 on every beat except the last, which gets 111.
  - On ack:
    - Address increments by 4; the remaining count decrements.
    - Writes pop the FIFO.
    - Reads capture wbm_dat_i into rdat.
    - The retry counter clears.
- Response priority: err > rty > ack when they are sampled together.
- err: drop cyc/stb, flush the FIFO, go to DONE with err=1.
- rty: drop cyc/stb, go to BACKOFF, increment the retry counter.
  - When the counter exceeds RTY_MAX, go to DONE with err=1 instead.
- BACKOFF
  - Lasts one cycle with cyc=0.
  - Returns to BUS and resumes at the current beat; address, remaining count and FIFO head are preserved.
  - CTI is recomputed from the remaining count.
- Last beat acked: drop cyc/stb, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address wraps modulo 2^32. No 1 KB boundary check; the command source guarantees it.
- Reset values: every output 0, except wbm_cti_o=000 and wbm_bte_o=00. FIFO empty, FSM in IDLE.

## Timing
- All wbm_*_o outputs are registered.
- The first cyc/stb is asserted:
  - Reads: the cycle after command accept.
  - Writes: the cycle after the last wdat push.
- One beat per cycle while ack is held high. stb never deasserts mid-burst except on rty or err.
- rdat_valid is registered, one cycle after the sampled ack.
- done is asserted the cycle after the terminating ack, err or exhausted rty, coincident with the last rdat_valid.
- Minimum read latency, accept to done, for N zero-wait beats: N+2 cycles.
- rst asserted mid-burst: cyc/stb are 0 the next cycle, no done pulse, any partial command is discarded.
- cmd_ready and wdat_ready are 0 outside IDLE and LOAD respectively.

## Configuration
- WB_BURST_MST_RTY_EN defined: retry/backoff behaviour as above.
- WB_BURST_MST_RTY_EN undefined:
  - wbm_rty_i is treated identically to wbm_err_i.
  - BACKOFF and the retry counter are removed.
  - RTY_MAX is unused.

## Structure
- Package wb_pkg holds:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - BTE_LINEAR=2'b00.
  - FSM state encoding.
- Sub-module wb_burst_fifo: synchronous FIFO, depth BURST_MAX, width 32.
  - Ports: push, pop, flush, count.
  - First-word fall-through, so wbm_dat_o is valid in the same cycle stb rises.

## Test plan
- Read, cmd_adr=0x4000_0010, cmd_len=3, ack held high:
  - Addresses 0x10, 0x14, 0x18, 0x1C.
  - CTI 010, 010, 010, 111.
  - Four rdat_valid; done at cycle 6 after accept with err=0.
- Single write, cmd_len=0, sel=4'b0011, wdat=0xDEADBEEF:
  - One beat with CTI 000, we=1, sel=0011, dat=0xDEADBEEF.
  - done with err=0.
- 4-beat write, err on beat 2:
  - cyc drops the next cycle.
  - done with err=1; FIFO count 0; cmd_ready=1 the following cycle.
- 4-beat read, rty on beat 1 then acks (RTY_EN defined):
  - One cyc-low cycle.
  - Resumes at start+4 with CTI 010.
  - Exactly 4 rdat_valid.
- rty held permanently with RTY_MAX=2:
  - Three bus attempts, then done with err=1.
  - With the macro undefined: done with err=1 after the first rty.
- rst during beat 2 of an 8-beat write:
  - cyc=0 next cycle, no done, FIFO empty.
  - A following read command completes normally.
